// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin sharing of one UART transmitter.           |
// | Optional WAIT_START watchdog: define UART_ARB_TIMEOUT_EN.   Rev 1.0     |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic [DATA_BITS-1:0]         tx_data_o,
  output logic                         tx_data_vld_o,
  input  logic                         tx_active_i,
  output logic                         busy_o,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic                         timeout_o
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_END   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic                 done_q, done_d;
  logic [OW-1:0]        pick;
  logic [DATA_BITS-1:0] pick_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`endif

  // Rotate the request vector so the slot after the last owner sits at bit 0,
  // take the lowest set bit, then rotate the offset back.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [OW-1:0]      last);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   off;
    int                   sum;
    dbl = {req, req};
    rot = NUM_REQ'(dbl >> (int'(last) + 1));
    off = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = int'(last) + 1 + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return OW'(sum);
  endfunction

  always_comb begin
    pick      = rr_pick(req_i, last_q);
    pick_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == OW'(k)) pick_data = req_data_i[k*DATA_BITS +: DATA_BITS];
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if ((|req_i) && !tx_active_i) begin
          owner_d = pick;
          data_d  = pick_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (tx_active_i) begin
          state_d = WAIT_END;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_END: begin
        if (!tx_active_i) begin
          done_d  = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      done_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // owner_q still names the finished requester during the done cycle.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_onehot
    assign gnt_o[k]  = (state_q == ISSUE) && (owner_q == OW'(k));
    assign done_o[k] = done_q && (owner_q == OW'(k));
  end

  assign tx_data_o     = data_q;
  assign tx_data_vld_o = (state_q == ISSUE);
  assign busy_o        = (state_q != IDLE);
  assign owner_o       = owner_q;

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: directed vectors for uart_tx_arbiter.    Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int DB = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0] gnt;
  logic [NR-1:0] done;
  logic [DB-1:0] tx_data;
  logic          vld;
  logic          tx_active;
  logic          busy;
  logic          owner;
  logic          tmo;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .DATA_BITS(DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .req_data_i(req_data),
    .gnt_o(gnt),
    .done_o(done),
    .tx_data_o(tx_data),
    .tx_data_vld_o(vld),
    .tx_active_i(tx_active),
    .busy_o(busy),
    .owner_o(owner),
    .timeout_o(tmo)
  );

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] gnt;
    logic       own;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [8];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input int maxc, output int lat);
    lat = 0;
    while (lat < maxc) begin
      tick();
      lat++;
      if (vld === 1'b1) return;
    end
    lat = -1;
  endtask

  // Called in the ISSUE cycle; returns in the cycle done_o should be visible.
  task automatic finish_char(input logic [1:0] exp_done, input logic [7:0] exp_data);
    tick();
    chk("hold_data_wait_start", 32'(tx_data), 32'(exp_data));
    chk("vld_single_pulse", 32'(vld), 32'd0);
    tx_active = 1'b1;
    tick();
    tick();
    chk("no_done_while_active", 32'(done), 32'd0);
    tick();
    tx_active = 1'b0;
    tick();
    chk("done_pulse", 32'(done), 32'(exp_done));
    chk("busy_falls_with_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int bad;

    vecs[0] = '{2'b01, 8'h55, 8'h00, 2'b01, 1'b0, 8'h55};
    vecs[1] = '{2'b01, 8'h3C, 8'h00, 2'b01, 1'b0, 8'h3C};
    vecs[2] = '{2'b11, 8'hA1, 8'hB2, 2'b10, 1'b1, 8'hB2};
    vecs[3] = '{2'b11, 8'hA1, 8'hB2, 2'b01, 1'b0, 8'hA1};
    vecs[4] = '{2'b10, 8'h00, 8'h7E, 2'b10, 1'b1, 8'h7E};
    vecs[5] = '{2'b10, 8'h00, 8'h81, 2'b10, 1'b1, 8'h81};
    vecs[6] = '{2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11};
    vecs[7] = '{2'b11, 8'h11, 8'h22, 2'b10, 1'b1, 8'h22};

    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    tx_active = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(tmo), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      req      = vecs[i].req;
      req_data = {vecs[i].d1, vecs[i].d0};
      wait_vld(5, lat);
      chk("vec_latency", 32'(lat), 32'd1);
      chk("vec_gnt", 32'(gnt), 32'(vecs[i].gnt));
      chk("vec_owner", 32'(owner), 32'(vecs[i].own));
      chk("vec_data", 32'(tx_data), 32'(vecs[i].data));
      chk("vec_busy", 32'(busy), 32'd1);
      req = '0;
      finish_char(vecs[i].gnt, vecs[i].data);
      tick();
      chk("vec_done_one_cycle", 32'(done), 32'd0);
      chk("vec_data_held_idle", 32'(tx_data), 32'(vecs[i].data));
    end

    // Line busy: no grant while the transmitter is active.
    tx_active = 1'b1;
    req       = 2'b10;
    req_data  = {8'hC3, 8'h00};
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gnt !== 2'b00 || busy !== 1'b0) bad++;
    end
    chk("line_busy_no_grant", 32'(bad), 32'd0);
    tx_active = 1'b0;
    wait_vld(5, lat);
    chk("line_busy_latency", 32'(lat), 32'd1);
    chk("line_busy_gnt", 32'(gnt), 32'(2'b10));
    chk("line_busy_data", 32'(tx_data), 32'h00C3);
    req = '0;
    finish_char(2'b10, 8'hC3);
    tick();

    // Contention: both requesters held continuously.
    req      = 2'b11;
    req_data = {8'hB2, 8'hA1};
    for (int i = 0; i < 4; i++) begin
      wait_vld(5, lat);
      chk("cont_latency", 32'(lat), 32'd1);
      chk("cont_owner", 32'(owner), 32'(i % 2));
      chk("cont_data", 32'(tx_data), (i % 2) ? 32'h00B2 : 32'h00A1);
      chk("cont_done_gap", 32'(done), 32'd0);
      finish_char((i % 2) ? 2'b10 : 2'b01, (i % 2) ? 8'hB2 : 8'hA1);
    end
    req = '0;
    tick();
    chk("cont_idle_after", 32'(busy), 32'd0);

    // Watchdog on a transmitter that never starts.
    req      = 2'b01;
    req_data = {8'h00, 8'h5A};
    wait_vld(5, lat);
    chk("wd_latency", 32'(lat), 32'd1);
    req = '0;
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (tmo === 1'b1) break;
    end
    chk("wd_timeout_cycle", 32'(n), 32'd17);
    chk("wd_no_done", 32'(done), 32'd0);
    chk("wd_idle", 32'(busy), 32'd0);
    tick();
    chk("wd_timeout_one_cycle", 32'(tmo), 32'd0);
    req = 2'b01;
    wait_vld(5, lat);
    chk("wd_regrant", 32'(gnt), 32'(2'b01));
    req = '0;
    tick();
`else
    n   = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (tmo !== 1'b0 || busy !== 1'b1 || done !== 2'b00) bad++;
    end
    chk("wd_off_stuck", 32'(bad), 32'd0);
`endif
    tx_active = 1'b1;
    tick();
    tick();

    // Reset mid-character, inside WAIT_END.
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_vld", 32'(vld), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_timeout", 32'(tmo), 32'd0);
    tx_active = 1'b0;
    tick();
    chk("mid_rst_no_done", 32'(done), 32'd0);
    rst      = 1'b0;
    req      = 2'b11;
    req_data = {8'hB2, 8'hA1};
    wait_vld(5, lat);
    chk("post_rst_latency", 32'(lat), 32'd1);
    chk("post_rst_gnt", 32'(gnt), 32'(2'b01));
    chk("post_rst_data", 32'(tx_data), 32'h00A1);
    req = '0;
    finish_char(2'b01, 8'hA1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
